// File: rtl/grad_orient_bin.sv
// grad_orient_bin
// Per-pixel gradient magnitude approximation and 45-degree orientation binning.
// The (dx, dy) stream comes from the gradient stage. Each result is tagged with
// its raster position, and the last pixel of a frame is flagged. Streaming only,
// with no backpressure. Latency is EN_DELAY cycles of enable alignment plus
// three register stages.

module grad_orient_bin #(
  parameter int EN_DELAY = 1,
  parameter int W0       = 640,
  parameter int H0       = 480,
  parameter int W1       = 320,
  parameter int H1       = 240,
  parameter int CW       = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_octave_sel,
  input  logic                 i_in_en,
  input  logic signed [7:0]    i_dx,
  input  logic signed [7:0]    i_dy,
  output logic [7:0]           o_mag,
  output logic [2:0]           o_bin,
  output logic [CW-1:0]        o_col,
  output logic [CW-1:0]        o_row,
  output logic                 o_out_valid,
  output logic                 o_frame_done
);

  // Frame sizes are stored as (size - 1), so the wrap tests are plain equality compares.
  localparam logic [CW-1:0] W0_M1 = CW'(W0 - 1);
  localparam logic [CW-1:0] H0_M1 = CW'(H0 - 1);
  localparam logic [CW-1:0] W1_M1 = CW'(W1 - 1);
  localparam logic [CW-1:0] H1_M1 = CW'(H1 - 1);

  // Returns the magnitude of a signed 8-bit value as an 8-bit unsigned value.
  // -128 maps to 128, which still fits in 8 unsigned bits.
  function automatic logic [7:0] abs8(input logic signed [7:0] v);
    logic [7:0] r;
    if (v[7]) begin
      r = 8'd0 - $unsigned(v);
    end else begin
      r = $unsigned(v);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Enable alignment
  // ---------------------------------------------------------------------------
  // The upstream stage registers dx/dy one cycle after it raises its enable.
  // The enable is therefore delayed here so that it lines up with its data.
  logic w_v0;

  generate
    if (EN_DELAY == 0) begin : g_no_dly
      assign w_v0 = i_in_en;
    end else begin : g_dly
      logic [EN_DELAY-1:0] r_en_dly;

      // Shift the upstream enable through EN_DELAY flops.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_en_dly <= '0;
        end else begin
          r_en_dly[0] <= i_in_en;
          for (int k = 1; k < EN_DELAY; k++) begin
            r_en_dly[k] <= r_en_dly[k-1];
          end
        end
      end

      assign w_v0 = r_en_dly[EN_DELAY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1: absolute values plus sign and zero flags
  // ---------------------------------------------------------------------------
  logic       r_v1;
  logic [7:0] r_ax1;
  logic [7:0] r_ay1;
  logic       r_sx1;
  logic       r_sy1;
  logic       r_zx1;
  logic       r_zy1;

  // Capture |dx| and |dy| together with the quadrant information.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_ax1 <= 8'd0;
      r_ay1 <= 8'd0;
      r_sx1 <= 1'b0;
      r_sy1 <= 1'b0;
      r_zx1 <= 1'b0;
      r_zy1 <= 1'b0;
    end else begin
      r_v1  <= w_v0;
      r_ax1 <= abs8(i_dx);
      r_ay1 <= abs8(i_dy);
      r_sx1 <= i_dx[7];
      r_sy1 <= i_dy[7];
      r_zx1 <= (i_dx == 8'sd0);
      r_zy1 <= (i_dy == 8'sd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: max/min ordering and strict-less-than flags
  // ---------------------------------------------------------------------------
  logic       r_v2;
  logic [7:0] r_mx2;
  logic [7:0] r_mn2;
  logic       r_ay_lt_ax2;
  logic       r_ax_lt_ay2;
  logic       r_sx2;
  logic       r_sy2;
  logic       r_zx2;
  logic       r_zy2;

  // Order the two magnitudes. The lt flags decide the diagonal ties in stage 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2        <= 1'b0;
      r_mx2       <= 8'd0;
      r_mn2       <= 8'd0;
      r_ay_lt_ax2 <= 1'b0;
      r_ax_lt_ay2 <= 1'b0;
      r_sx2       <= 1'b0;
      r_sy2       <= 1'b0;
      r_zx2       <= 1'b0;
      r_zy2       <= 1'b0;
    end else begin
      r_v2        <= r_v1;
      r_ay_lt_ax2 <= (r_ay1 < r_ax1);
      r_ax_lt_ay2 <= (r_ax1 < r_ay1);
      r_sx2       <= r_sx1;
      r_sy2       <= r_sy1;
      r_zx2       <= r_zx1;
      r_zy2       <= r_zy1;
      if (r_ax1 < r_ay1) begin
        r_mx2 <= r_ay1;
        r_mn2 <= r_ax1;
      end else begin
        r_mx2 <= r_ax1;
        r_mn2 <= r_ay1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 combinational: magnitude and orientation bin
  // ---------------------------------------------------------------------------
  // The largest result is 128 + 64 = 192, so the 8-bit sum cannot overflow.
  logic [7:0] w_mag;
  logic [2:0] w_bin;

  assign w_mag = r_mx2 + {1'b0, r_mn2[7:1]};

  // Choose the 45-degree sector. Each quadrant owns one of its two axis rays,
  // so every nonzero vector falls into exactly one branch.
  always_comb begin
    w_bin = 3'd0;
    if (r_zx2 && r_zy2) begin
      w_bin = 3'd0;
    end else if (!r_sx2 && !r_zx2 && !r_sy2) begin
      // dx > 0, dy >= 0
      w_bin = r_ay_lt_ax2 ? 3'd0 : 3'd1;
    end else if ((r_sx2 || r_zx2) && !r_sy2 && !r_zy2) begin
      // dx <= 0, dy > 0
      w_bin = r_ax_lt_ay2 ? 3'd2 : 3'd3;
    end else if (r_sx2 && (r_sy2 || r_zy2)) begin
      // dx < 0, dy <= 0
      w_bin = r_ay_lt_ax2 ? 3'd4 : 3'd5;
    end else if (!r_sx2 && r_sy2) begin
      // dx >= 0, dy < 0
      w_bin = r_ax_lt_ay2 ? 3'd6 : 3'd7;
    end else begin
      w_bin = 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster position and frame size
  // ---------------------------------------------------------------------------
  // r_col_cnt/r_row_cnt hold the position of the next pixel to be emitted.
  // The frame size is latched when the first pixel of a frame leaves. That
  // pixel already uses the freshly selected size.
  logic [CW-1:0] r_col_cnt;
  logic [CW-1:0] r_row_cnt;
  logic [CW-1:0] r_w_m1;
  logic [CW-1:0] r_h_m1;
  logic          w_at_origin;
  logic [CW-1:0] w_cur_w_m1;
  logic [CW-1:0] w_cur_h_m1;
  logic          w_last_col;
  logic          w_last_row;

  assign w_at_origin = (r_col_cnt == {CW{1'b0}}) && (r_row_cnt == {CW{1'b0}});

  // Select the frame size in force for the pixel that is about to be emitted.
  always_comb begin
    w_cur_w_m1 = r_w_m1;
    w_cur_h_m1 = r_h_m1;
    if (w_at_origin) begin
      if (i_octave_sel) begin
        w_cur_w_m1 = W1_M1;
        w_cur_h_m1 = H1_M1;
      end else begin
        w_cur_w_m1 = W0_M1;
        w_cur_h_m1 = H0_M1;
      end
    end else begin
      w_cur_w_m1 = r_w_m1;
      w_cur_h_m1 = r_h_m1;
    end
  end

  assign w_last_col = (r_col_cnt == w_cur_w_m1);
  assign w_last_row = (r_row_cnt == w_cur_h_m1);

  // Advance the raster counters and latch the frame size at the start of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_w_m1    <= W0_M1;
      r_h_m1    <= H0_M1;
    end else if (r_v2) begin
      if (w_at_origin) begin
        r_w_m1 <= w_cur_w_m1;
        r_h_m1 <= w_cur_h_m1;
      end
      if (w_last_col) begin
        r_col_cnt <= '0;
        if (w_last_row) begin
          r_row_cnt <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        r_col_cnt <= r_col_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 output registers
  // ---------------------------------------------------------------------------
  // Register the results. The data outputs hold their last value while no
  // pixel is emitted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mag        <= 8'd0;
      o_bin        <= 3'd0;
      o_col        <= '0;
      o_row        <= '0;
      o_out_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else if (r_v2) begin
      o_mag        <= w_mag;
      o_bin        <= w_bin;
      o_col        <= r_col_cnt;
      o_row        <= r_row_cnt;
      o_out_valid  <= 1'b1;
      o_frame_done <= w_last_col && w_last_row;
    end else begin
      o_out_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end
  end

endmodule
